neuron_mac: RTL and testbench

Serial multiply-accumulate neuron that feeds the ReLU activation stage. Per neuron it loads a bias, accepts N_INPUTS (activation, weight) pairs over a valid/ready handshake, and accumulates them at full precision. It then rounds and saturates the sum back to 16-bit signed Q8.8 fixed point. It presents the result on `neuron` with a one-cycle `neuron_done` pulse, which the activation stage samples directly.

---
 rtl/nn_pkg.sv | 25 ++
 rtl/neuron_mac_if.sv | 25 ++
 rtl/neuron_mac_q_round_sat.sv | 44 ++++
 rtl/neuron_mac.sv | 90 +++++++++
 tb/tb_neuron_mac.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared neural-network package: Q8.8 data format constants, the layer
// controller state encoding and the accumulator sizing helper.
package nn_pkg;

    localparam int DATA_W        = 16;
    localparam int DEF_FRAC_BITS = 8;

    localparam logic [DATA_W-1:0] Q_ONE = 16'h0100;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Full-precision accumulator width: 32-bit product, headroom for n terms
    // plus the bias, and one extra sign bit so it can never overflow.
    function automatic int acc_width(input int n);
        return 32 + $clog2(n + 1) + 1;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Handshake and data bundle between a neuron_mac and its driver/consumer.
interface neuron_mac_if;
    import nn_pkg::*;

    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] weight;
    logic                     in_ready;
    logic                     busy;
    logic signed [DATA_W-1:0] neuron;
    logic                     neuron_done;

    modport master (
        output start, bias, in_valid, in_data, weight,
        input  in_ready, busy, neuron, neuron_done
    );

    modport slave (
        input  start, bias, in_valid, in_data, weight,
        output in_ready, busy, neuron, neuron_done
    );

endinterface

// File: rtl/neuron_mac_q_round_sat.sv
// Rounds a wide accumulator back to Q8.8 (half-LSB, toward +inf) and clamps it.
// Build option: define NEURON_MAC_SAT_EN to enable the saturating clamp;
// without it the result is the wrapped low 16 bits of the rounded value.
module q_round_sat
    import nn_pkg::*;
#(
    parameter int ACC_W     = 38,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] q
);

    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF =
        {{(EXT_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] e;
        e = {v[ACC_W-1], v};
        e = e + HALF;
        return e >>> FRAC_BITS;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [EXT_W-1:0] v);
`ifdef NEURON_MAC_SAT_EN
        logic signed [EXT_W-1:0] max_v;
        logic signed [EXT_W-1:0] min_v;
        max_v = {{(EXT_W-DATA_W){1'b0}}, Q_MAX};
        min_v = {{(EXT_W-DATA_W){1'b1}}, Q_MIN};
        if (v > max_v)
            return Q_MAX;
        else if (v < min_v)
            return Q_MIN;
        else
            return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    assign q = sat_q(round_shift(acc));

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: bias load, N_INPUTS handshaked
// (activation, weight) products, then round/saturate to Q8.8 with a done pulse.
// Build option: NEURON_MAC_SAT_EN selects saturating vs wrapping output.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input logic          clk,
    input logic          rst,
    neuron_mac_if.slave  bus
);

    localparam int ACC_W = acc_width(N_INPUTS);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t                     state;
    logic signed [ACC_W-1:0]    acc_p0;
    logic [CNT_W-1:0]           cnt;
    logic                       in_ready_r;
    logic                       busy_r;
    logic signed [DATA_W-1:0]   neuron_p1;
    logic                       done_p1;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   q_rounded;

    assign prod = bus.in_data * bus.weight;

    q_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round (
        .acc (acc_p0),
        .q   (q_rounded)
    );

    // Controller and datapath: load bias, accumulate accepted pairs, register result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc_p0     <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            neuron_p1  <= '0;
            done_p1    <= 1'b0;
        end else begin
            done_p1 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc_p0     <= ACC_W'(bus.bias) <<< FRAC_BITS;
                        cnt        <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_p0 <= acc_p0 + ACC_W'(prod);
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            in_ready_r <= 1'b0;
                            state      <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    neuron_p1 <= q_rounded;
                    done_p1   <= 1'b1;
                    busy_r    <= 1'b0;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.busy        = busy_r;
    assign bus.neuron      = neuron_p1;
    assign bus.neuron_done = done_p1;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed testbench for neuron_mac with a result scoreboard.
module tb_neuron_mac;
    import nn_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neuron_mac_if bus ();

    neuron_mac #(
        .N_INPUTS  (N),
        .FRAC_BITS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    longint      cyc = 0;
    logic [15:0] sb[$];
    int          done_cnt = 0;
    longint      done_cyc = 0;
    longint      prev_done_cyc = 0;
    logic        prev_done = 1'b0;

    logic signed [15:0] pa[N];
    logic signed [15:0] pw[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact sum in 64 bits, half-up rounding, then clamp or wrap.
    function automatic logic [15:0] model(input logic signed [15:0] b);
        longint s;
        s = longint'(b) * 256;
        for (int i = 0; i < N; i++)
            s = s + longint'(pa[i]) * longint'(pw[i]);
        s = (s + 128) >>> 8;
`ifdef NEURON_MAC_SAT_EN
        if (s > 32767)
            s = 32767;
        else if (s < -32768)
            s = -32768;
`endif
        return s[15:0];
    endfunction

    // Output monitor: protocol invariants and scoreboard pop on each done pulse.
    always @(negedge clk) begin
        logic [15:0] exp_q;
        if (bus.in_ready)
            check("ready_implies_busy", 32'(bus.busy), 32'd1);
        if (bus.neuron_done) begin
            check("done_state_outputs", 32'({bus.in_ready, bus.busy}), 32'd0);
            check("done_single_cycle", 32'(prev_done), 32'd0);
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            done_cnt++;
            check("result_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_q = sb.pop_front();
                check("sb_neuron", {16'h0, bus.neuron}, {16'h0, exp_q});
            end
        end
        prev_done = bus.neuron_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b);
        bus.start = 1'b1;
        bus.bias  = b;
        sb.push_back(model(b));
        tick();
        bus.start = 1'b0;
        check("ready_after_start", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic feed(input bit gaps, output longint last_acc);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        last_acc = 0;
        while (i < N && guard < 200) begin
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = pa[i];
            bus.weight   = pw[i];
            if (gaps) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.bias  = 16'($urandom);
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) begin
                i++;
                last_acc = cyc;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("feed_complete", 32'(i), 32'(N));
    endtask

    task automatic wait_done(input longint last_acc, input int exp_cnt);
        int g = 0;
        while (done_cnt < exp_cnt && g < 20) begin
            tick();
            g++;
        end
        check("done_seen", 32'(done_cnt), 32'(exp_cnt));
        check("done_latency", 32'(done_cyc - last_acc), 32'd1);
        check("done_pulse_end", 32'(bus.neuron_done), 32'd0);
    endtask

    initial begin
        longint la;
        longint la2;
        int     dc;

        bus.start    = 1'b0;
        bus.bias     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.weight   = '0;

        #12;
        check("rst_neuron",   {16'h0, bus.neuron}, 32'd0);
        check("rst_done",     32'(bus.neuron_done), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // in_valid while idle must not be consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7FFF;
        bus.weight   = 16'h7FFF;
        tick();
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        check("idle_busy",     32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;

        // basic accumulate: 1.0 + 4 * (1.0 * 0.5) = 3.0
        for (int i = 0; i < N; i++) begin pa[i] = 16'h0100; pw[i] = 16'h0080; end
        do_start(16'h0100);
        feed(1'b0, la);
        wait_done(la, 1);
        check("basic_value", {16'h0, bus.neuron}, 32'h0000_0300);

        // positive overflow
        for (int i = 0; i < N; i++) begin pa[i] = 16'h7FFF; pw[i] = 16'h7FFF; end
        do_start(16'h7F00);
        feed(1'b0, la);
        wait_done(la, 2);
`ifdef NEURON_MAC_SAT_EN
        check("pos_sat", {16'h0, bus.neuron}, 32'h0000_7FFF);
`endif

        // negative overflow
        for (int i = 0; i < N; i++) begin pa[i] = 16'h8000; pw[i] = 16'h7FFF; end
        do_start(16'h0000);
        feed(1'b0, la);
        wait_done(la, 3);
`ifdef NEURON_MAC_SAT_EN
        check("neg_sat", {16'h0, bus.neuron}, 32'h0000_8000);
`endif

        // half-LSB rounding: +0x80 rounds up to 1, -0x80 rounds up to 0
        for (int i = 0; i < N; i++) begin pa[i] = 16'h0000; pw[i] = 16'h0000; end
        pa[0] = 16'h0001; pw[0] = 16'h0080;
        do_start(16'h0000);
        feed(1'b0, la);
        wait_done(la, 4);
        check("round_half_pos", {16'h0, bus.neuron}, 32'h0000_0001);
        pa[0] = 16'hFFFF;
        do_start(16'h0000);
        feed(1'b0, la);
        wait_done(la, 5);
        check("round_half_neg", {16'h0, bus.neuron}, 32'h0000_0000);

        // random in_valid gaps with start pulses and bias changes while busy
        for (int i = 0; i < N; i++) begin pa[i] = 16'($urandom); pw[i] = 16'($urandom_range(0, 16'h03FF)); end
        do_start(16'hFE80);
        feed(1'b1, la);
        wait_done(la, 6);
        tick();
        tick();
        check("gap_single_result", 32'(done_cnt), 32'd6);
        check("gap_idle_after", 32'(bus.busy), 32'd0);

        // back-to-back neurons: start issued in the DONE cycle
        for (int i = 0; i < N; i++) begin pa[i] = 16'h0200; pw[i] = 16'h0100; end
        do_start(16'h0040);
        feed(1'b0, la);
        tick();
        check("b2b_done_cycle", 32'(bus.neuron_done), 32'd1);
        for (int i = 0; i < N; i++) begin pa[i] = 16'hFF00; pw[i] = 16'h0180; end
        do_start(16'h0300);
        feed(1'b0, la2);
        wait_done(la2, 8);
        check("b2b_period", 32'(done_cyc - prev_done_cyc), 32'(N + 2));

        // asynchronous reset after two accepted pairs
        for (int i = 0; i < N; i++) begin pa[i] = 16'h0100; pw[i] = 16'h0100; end
        do_start(16'h1234);
        bus.in_valid = 1'b1;
        bus.in_data  = pa[0];
        bus.weight   = pw[0];
        tick();
        tick();
        bus.in_valid = 1'b0;
        dc = done_cnt;
        #2 rst = 1'b0;
        sb.delete();
        #1;
        check("arst_neuron",   {16'h0, bus.neuron}, 32'd0);
        check("arst_done",     32'(bus.neuron_done), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_busy",     32'(bus.busy), 32'd0);
        tick();
        tick();
        check("arst_no_done", 32'(done_cnt), 32'(dc));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // fresh neuron after reset: 0.5 + 4 * 1.0 = 4.5
        do_start(16'h0080);
        feed(1'b0, la);
        wait_done(la, dc + 1);
        check("post_rst_value", {16'h0, bus.neuron}, 32'h0000_0480);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
